// File: rtl/mult_seq_ctrl_pkg.sv
// Shared constants, state encoding and negation helpers for the sequential multiplier.
package mult_seq_ctrl_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int MULT_ITER  = 32;
  localparam int CNT_W      = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic logic [DATA_WIDTH-1:0] twos_comp32(input logic [DATA_WIDTH-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [2*DATA_WIDTH-1:0] twos_comp64(input logic [2*DATA_WIDTH-1:0] v);
    return ~v + 1'b1;
  endfunction

endpackage

// File: rtl/mult_seq_dp.sv
// Shift-add datapath: multiplicand register, HI/LO accumulator and the single 33-bit add.
module mult_seq_dp
  import mult_seq_ctrl_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic                  fix_i,
  input  logic                  neg_i,
  input  logic                  signed_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);

  logic [DATA_WIDTH-1:0] mcnd_q, mcnd_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] addend;
  logic [2*DATA_WIDTH-1:0] fixed;

  assign addend = lo_q[0] ? mcnd_q : '0;
  assign sum    = {1'b0, hi_q} + {1'b0, addend};
  assign fixed  = twos_comp64({hi_q, lo_q});

  always_comb begin
    mcnd_d = mcnd_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (load_i) begin
      // 0x80000000 negates to itself, which is already the right unsigned magnitude.
      mcnd_d = (signed_i && a_i[DATA_WIDTH-1]) ? twos_comp32(a_i) : a_i;
      lo_d   = (signed_i && b_i[DATA_WIDTH-1]) ? twos_comp32(b_i) : b_i;
      hi_d   = '0;
    end else if (step_i) begin
      {hi_d, lo_d} = {sum, lo_q[DATA_WIDTH-1:1]};
    end else if (fix_i && neg_i) begin
      {hi_d, lo_d} = fixed;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      mcnd_q <= mcnd_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential signed/unsigned 32x32 multiplier: FSM, iteration counter and operand latch.
//   state   | meaning
//   IDLE    | waiting for START
//   PREP    | build operand magnitudes, load datapath, clear counter
//   ITER    | one shift-add per cycle, 32 cycles
//   FIX     | negate 64-bit result when operand signs differ
//   DONE    | result valid for one cycle; START here chains the next op
module mult_seq_ctrl
  import mult_seq_ctrl_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  SIGNED,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO,
  output logic                  BUSY,
  output logic                  DONE
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  neg_q, neg_d;
  logic                  sgn_q, sgn_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic                  load, step, fix;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    sgn_d   = sgn_q;
    a_d     = a_q;
    b_d     = b_q;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (START) begin
          state_d = ST_PREP;
          a_d     = A;
          b_d     = B;
          sgn_d   = SIGNED;
          neg_d   = SIGNED & (A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1]);
        end
      end
      ST_PREP: begin
        load    = 1'b1;
        cnt_d   = '0;
        state_d = ST_ITER;
      end
      ST_ITER: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MULT_ITER - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        fix     = 1'b1;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      sgn_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      sgn_q   <= sgn_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign BUSY = (state_q == ST_PREP) || (state_q == ST_ITER) || (state_q == ST_FIX);
  assign DONE = (state_q == ST_DONE);

  mult_seq_dp u_dp (
    .clk_i   (CLK),
    .rst_i   (RST),
    .load_i  (load),
    .step_i  (step),
    .fix_i   (fix),
    .neg_i   (neg_q),
    .signed_i(sgn_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .hi_o    (HI),
    .lo_o    (LO)
  );

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: products, latency, handshake and reset abort.
module tb_mult_seq_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        SIGNED = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] HI, LO;
  logic        BUSY, DONE;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  mult_seq_ctrl dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .SIGNED(SIGNED),
    .A     (A),
    .B     (B),
    .HI    (HI),
    .LO    (LO),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the accept edge.
  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    START  = 1'b1;
    SIGNED = sgn;
    A      = a;
    B      = b;
    @(posedge CLK); #1;
    START  = 1'b0;
  endtask

  // Counts edges after the accept edge until DONE, bounded.
  task automatic wait_done(output int n, output int busy_n, output int overlap);
    busy_n  = BUSY ? 1 : 0;
    overlap = 0;
    n       = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge CLK); #1;
      if (BUSY && DONE) overlap++;
      if (DONE) begin
        n = i;
        break;
      end
      if (BUSY) busy_n++;
    end
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int n, bn, ov;
    start_op(sgn, a, b);
    wait_done(n, bn, ov);
    chk({tag, "_lat"}, 64'(n), 64'd34);
    chk({tag, "_prod"}, {HI, LO}, exp);
    chk({tag, "_ovl"}, 64'(ov), 64'd0);
    @(posedge CLK); #1;
    chk({tag, "_pulse"}, {63'd0, DONE}, 64'd0);
  endtask

  initial begin
    int n, bn, ov;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out", {HI, LO, 30'd0, BUSY, DONE}, '0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // 3 x 5 unsigned with busy-length check
    start_op(1'b0, 32'd3, 32'd5);
    wait_done(n, bn, ov);
    chk("u3x5_lat", 64'(n), 64'd34);
    chk("u3x5_busy", 64'(bn), 64'd34);
    chk("u3x5_prod", {HI, LO}, 64'h0000_0000_0000_000F);
    @(posedge CLK); #1;
    chk("u3x5_idle", {62'd0, BUSY, DONE}, 64'd0);

    run_op("uff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("sm7x6", 1'b1, 32'hFFFF_FFF9, 32'h0000_0006, 64'hFFFF_FFFF_FFFF_FFD6);
    run_op("smin2", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op("sminx1", 1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000);
    run_op("u7x6", 1'b0, 32'h0000_0007, 32'hFFFF_FFFA, 64'h0000_0006_FFFF_FFD6);

    // START pulsed mid-ITER must be ignored
    start_op(1'b0, 32'h0000_1234, 32'h0000_0010);
    repeat (5) @(posedge CLK);
    #1;
    START = 1'b1; A = 32'd99; B = 32'd99; SIGNED = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    wait_done(n, bn, ov);
    chk("ign_lat", 64'(n + 6), 64'd34);
    chk("ign_prod", {HI, LO}, 64'h0000_0000_0001_2340);

    // chain 2 x 2 from the DONE cycle
    start_op(1'b0, 32'd2, 32'd2);
    chk("b2b_busy", {62'd0, BUSY, DONE}, 64'd2);
    wait_done(n, bn, ov);
    chk("b2b_lat", 64'(n), 64'd34);
    chk("b2b_prod", {HI, LO}, 64'd4);
    @(posedge CLK); #1;

    // reset mid-ITER
    start_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF1);
    repeat (11) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("abort_out", {HI, LO, 30'd0, BUSY, DONE}, '0);
    @(posedge CLK); #1;
    RST = 1'b0;
    ov = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (DONE || BUSY) ov++;
    end
    chk("abort_quiet", 64'(ov), 64'd0);

    run_op("u9x9", 1'b0, 32'd9, 32'd9, 64'h51);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
